// File: rtl/dma_xfer_engine.sv
// Word-copy DMA initiator: reads a 16-bit word from src, writes it to dst, and repeats
// xfer_len times. It never drives dma_en onto the protected key region and stops on abort.
module dma_xfer_engine #(
  parameter logic [15:0] KMEM_BASE = 16'h6A00,
  parameter logic [15:0] KMEM_SIZE = 16'h001F,
  parameter int          LEN_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic             abort,
  output logic [15:0]      dma_addr,
  output logic             dma_en,
  output logic             dma_we,
  output logic [15:0]      dma_din,
  input  logic [15:0]      dma_dout,
  input  logic             dma_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_left,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  // Bus handshake: an access completes on a rising edge where dma_en=1 and dma_ready=1;
  // while dma_ready=0 the engine holds dma_addr/dma_we/dma_din/dma_en unchanged.

  logic [1:0]       state_q;
  logic [15:0]      src_q;
  logic [15:0]      dst_q;
  logic [15:0]      buf_q;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic             done_q;

  logic [15:0] cur_addr;
  logic [16:0] kmem_end;
  logic        addr_prot;
  logic        stop;

  always_comb begin
    cur_addr = 16'h0000;
    case (state_q)
      S_RD:    cur_addr = src_q;
      S_WR:    cur_addr = dst_q;
      default: cur_addr = 16'h0000;
    endcase
  end

  // 17-bit bound so a region ending at the top of the address space cannot wrap.
  assign kmem_end  = {1'b0, KMEM_BASE} + {1'b0, KMEM_SIZE};
  assign addr_prot = ({1'b0, cur_addr} >= {1'b0, KMEM_BASE}) && ({1'b0, cur_addr} < kmem_end);

  assign busy       = (state_q != S_IDLE);
  assign stop       = busy && (abort || addr_prot);
  assign dma_en     = busy && !stop;
  assign dma_we     = (state_q == S_WR);
  assign dma_addr   = cur_addr;
  assign dma_din    = buf_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_left = len_q;
  assign state_dbg  = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      buf_q   <= 16'h0000;
      len_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= xfer_len;
            err_q <= 1'b0;
            if (xfer_len == '0) done_q  <= 1'b1;
            else                state_q <= S_RD;
          end
        end
        S_RD: begin
          if (stop) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else if (dma_ready) begin
            buf_q   <= dma_dout;
            state_q <= S_WR;
          end
        end
        S_WR: begin
          if (stop) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else if (dma_ready) begin
            src_q <= src_q + 16'd2;
            dst_q <= dst_q + 16'd2;
            len_q <= len_q - LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Directed bench for dma_xfer_engine: a transfer-level model fills an expected handshake queue,
// a per-cycle compare process checks every bus handshake, and literal checks pin the model.
module tb_dma_xfer_engine;
  localparam int W = 33;  // {we, addr[15:0], data[15:0]}

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = 16'h0;
  logic [15:0] dst_addr = 16'h0;
  logic [7:0]  xfer_len = 8'h0;
  logic        abort = 1'b0;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic        dma_we;
  logic [15:0] dma_din;
  logic [15:0] dma_dout;
  logic        dma_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  words_left;
  logic [1:0]  state_dbg;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int en_cnt = 0;
  int busy_cnt = 0;
  int stall_cnt = 0;
  bit stall_mode = 1'b0;
  logic [W-1:0] exp_q[$];

  dma_xfer_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .xfer_len(xfer_len), .abort(abort), .dma_addr(dma_addr), .dma_en(dma_en), .dma_we(dma_we),
    .dma_din(dma_din), .dma_dout(dma_dout), .dma_ready(dma_ready), .busy(busy), .done(done),
    .err(err), .words_left(words_left), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a ^ 16'hC35A) + 16'h0101;
  endfunction

  function automatic bit is_prot(input logic [15:0] a);
    int ai;
    ai = int'(a);
    return (ai >= 'h6A00) && (ai < 'h6A00 + 'h1F);
  endfunction

  // memory source: every address reads back a fixed pattern
  assign dma_dout = pat(dma_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // memory ready driver: optionally stalls each read 3 cycles
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      dma_ready = 1'b1;
      stall_cnt = 0;
    end else if (dma_en && !dma_we) begin
      if (stall_cnt == 3) begin
        dma_ready = 1'b1;
        stall_cnt = 0;
      end else begin
        dma_ready = 1'b0;
        stall_cnt++;
      end
    end else begin
      dma_ready = 1'b1;
      stall_cnt = 0;
    end
  end

  // transfer model: word i is read at src+2i then written to dst+2i; stops at a protected
  // address or at word abort_at; words_left counts words whose write has not completed
  task automatic model_xfer(input logic [15:0] s, input logic [15:0] d, input int len,
                            input int abort_at, output int exp_left, output bit exp_err);
    logic [15:0] ra;
    logic [15:0] wa;
    exp_left = len;
    exp_err  = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin exp_err = 1'b1; return; end
      ra = s + 16'(2 * i);
      if (is_prot(ra)) begin exp_err = 1'b1; return; end
      exp_q.push_back({1'b0, ra, 16'h0000});
      wa = d + 16'(2 * i);
      if (is_prot(wa)) begin exp_err = 1'b1; return; end
      exp_q.push_back({1'b1, wa, pat(ra)});
      exp_left--;
    end
  endtask

  // scoreboard / per-cycle compare
  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (reset_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (dma_en) begin
        en_cnt++;
        check("guard_no_prot", 32'(is_prot(dma_addr)), 32'd0);
      end
      if (prev_stall && !abort) begin
        check("stall_en", 32'(dma_en), 32'd1);
        check("stall_addr", 32'(dma_addr), 32'(prev_addr));
        check("stall_we", 32'(dma_we), 32'(prev_we));
      end
      if (dma_en && dma_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL hs_extra: got we=%0d addr=%0h expected no access", dma_we, dma_addr);
        end else begin
          e = exp_q.pop_front();
          check("hs_we", 32'(dma_we), 32'(e[32]));
          check("hs_addr", 32'(dma_addr), 32'(e[31:16]));
          if (dma_we) check("hs_data", 32'(dma_din), 32'(e[15:0]));
        end
      end
      prev_stall = dma_en && !dma_ready;
      prev_addr  = dma_addr;
      prev_we    = dma_we;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [7:0] len);
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; xfer_len = len; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int k;
    k = 0;
    while (busy && k < max_cyc) begin @(negedge clk); k++; end
    if (busy) begin
      n_total++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, k);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_counts();
    done_cnt = 0; en_cnt = 0; busy_cnt = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_en"}, 32'(dma_en), 32'd0);
    check({tag, "_we"}, 32'(dma_we), 32'd0);
    check({tag, "_addr"}, 32'(dma_addr), 32'd0);
    check({tag, "_din"}, 32'(dma_din), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_left"}, 32'(words_left), 32'd0);
  endtask

  initial begin
    int el;
    bit ee;
    int k;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // zero-wait copy of 3 words
    clear_counts();
    model_xfer(16'h1000, 16'h2000, 3, -1, el, ee);
    check("t1_model_a3", 32'(exp_q[3][31:16]), 32'h2002);
    check("t1_model_a4", 32'(exp_q[4][31:16]), 32'h1004);
    do_start(16'h1000, 16'h2000, 8'd3);
    wait_idle("t1", 100);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd6);
    check("t1_en_cycles", 32'(en_cnt), 32'd6);
    check("t1_left", 32'(words_left), 32'(el));
    check("t1_err", 32'(err), 32'(ee));

    // same copy with 3 stall cycles per read
    clear_counts();
    stall_mode = 1'b1;
    model_xfer(16'h1000, 16'h2000, 3, -1, el, ee);
    do_start(16'h1000, 16'h2000, 8'd3);
    wait_idle("t2", 200);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);
    check("t2_busy_cycles", 32'(busy_cnt), 32'd15);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_err", 32'(err), 32'(ee));
    stall_mode = 1'b0;

    // second write lands on key region base
    clear_counts();
    model_xfer(16'h3000, 16'h69FE, 2, -1, el, ee);
    check("t3_model_left", 32'(el), 32'd1);
    do_start(16'h3000, 16'h69FE, 8'd2);
    wait_idle("t3", 100);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);
    check("t3_err", 32'(err), 32'd1);
    check("t3_done_cnt", 32'(done_cnt), 32'd0);
    check("t3_left", 32'(words_left), 32'(el));

    // abort during second read of a 4-word copy
    clear_counts();
    stall_mode = 1'b1;
    model_xfer(16'h4000, 16'h5000, 4, 1, el, ee);
    check("t4_model_left", 32'(el), 32'd3);
    do_start(16'h4000, 16'h5000, 8'd4);
    k = 0;
    while (!(dma_en && !dma_we && dma_addr == 16'h4002) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("t4_reached_rd2", 32'(dma_addr), 32'h4002);
    abort = 1'b1;
    #1;
    check("t4_abort_gate", 32'(dma_en), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_err", 32'(err), 32'(ee));
    check("t4_left", 32'(words_left), 32'(el));
    @(posedge clk); #1;
    check("t4_left_frozen", 32'(words_left), 32'd3);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd0);
    stall_mode = 1'b0;

    // zero-length start clears err and pulses done without bus traffic
    clear_counts();
    do_start(16'h4000, 16'h5000, 8'd0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err_cleared", 32'(err), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_en_cycles", 32'(en_cnt), 32'd0);

    // start is ignored while abort is high
    clear_counts();
    abort = 1'b1;
    do_start(16'h1000, 16'h2000, 8'd1);
    check("t6_busy", 32'(busy), 32'd0);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_done_cnt", 32'(done_cnt), 32'd0);

    // source address wraps through 0x0000
    clear_counts();
    model_xfer(16'hFFFE, 16'h7000, 2, -1, el, ee);
    check("t7_model_a0", 32'(exp_q[0][31:16]), 32'hFFFE);
    check("t7_model_a2", 32'(exp_q[2][31:16]), 32'h0000);
    do_start(16'hFFFE, 16'h7000, 8'd2);
    wait_idle("t7", 100);
    check("t7_q_empty", 32'(exp_q.size()), 32'd0);
    check("t7_err", 32'(err), 32'd0);
    check("t7_done_cnt", 32'(done_cnt), 32'd1);

    // asynchronous reset in the middle of a write
    model_xfer(16'h1000, 16'h2000, 3, -1, el, ee);
    do_start(16'h1000, 16'h2000, 8'd3);
    k = 0;
    while (!dma_we && k < 100) begin @(posedge clk); #1; k++; end
    check("t8_reached_wr", 32'(dma_we), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("t8");
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t8_idle_after", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dma_xfer_engine.md
Name: dma_xfer_engine

Overview:
- DMA initiator that copies a block of 16-bit words from a source to a destination address range.
- Drives the dma_addr / dma_en bus that the DMA access monitor observes.
- Refuses to touch the key memory region itself and aborts cleanly when the monitor or the system raises abort.
- Sits between a software-programmed config port and the memory DMA port.

Parameters:
- KMEM_BASE, 16'h6A00, first address of the protected key region.
- KMEM_SIZE, 16'h001F, size in bytes of the protected key region.
- LEN_W, 8, width of the transfer word count.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transfer; ignored while busy.
- src_addr  in  16  source byte address, sampled on accepted start.
- dst_addr  in  16  destination byte address, sampled on accepted start.
- xfer_len  in  LEN_W  number of words to copy, sampled on accepted start.
- abort  in  1  level; forces termination (tied to the access monitor's reset output).
- dma_addr  out  16  bus address.
- dma_en  out  1  bus request.
- dma_we  out  1  1 means write, 0 means read.
- dma_din  out  16  write data to memory.
- dma_dout  in  16  read data from memory, valid when dma_ready=1 on a read.
- dma_ready  in  1  memory accepts/completes the current access this cycle.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag; cleared on the next accepted start.
- words_left  out  LEN_W  remaining words.

Behaviour:
- Reset is asynchronous and active-low.
  - While reset_n=0: state=IDLE; all address, count and data registers are 0.
  - Outputs under reset: dma_en=0, dma_we=0, dma_addr=0, dma_din=0, busy=0, done=0, err=0, words_left=0.
- States: IDLE, RD, WR.
- IDLE:
  - start=1 latches src, dst and len, clears err, and loads words_left=xfer_len.
  - If xfer_len≠0, next state is RD.
  - If xfer_len=0, the engine stays IDLE and pulses done next cycle with no bus activity.
- RD:
  - Outputs: dma_addr=src, dma_we=0, dma_en=1.
  - Hold all outputs stable until dma_ready=1.
  - On dma_ready=1: capture dma_dout into the data buffer, then go to WR.
- WR:
  - Outputs: dma_addr=dst, dma_we=1, dma_din=buffer, dma_en=1.
  - On dma_ready=1: src+=2, dst+=2, words_left-=1.
  - If words_left was 1, return to IDLE and pulse done (done high the cycle after the final write handshake). Otherwise go to RD.
- Address arithmetic is modulo 2^16: 16'hFFFE+2 wraps to 16'h0000 with no error.
- Region guard:
  - The current bus address is protected when addr >= KMEM_BASE and addr < KMEM_BASE+KMEM_SIZE. Evaluate this with a 17-bit sum so it cannot overflow.
  - In RD or WR with a protected address, dma_en=0 combinationally, so the protected address is never presented with dma_en=1.
  - The engine then moves to IDLE next cycle, sets err=1, and does not pulse done.
- Abort:
  - abort=1 in RD or WR gates dma_en to 0 combinationally in that cycle.
  - Next state is IDLE with err=1, no done pulse, and words_left frozen at its current value.
  - abort in IDLE has no effect, but start is ignored while abort=1.
  - A simultaneous abort and dma_ready: abort wins. The data or count update is discarded.
- Simultaneous events:
  - start while busy is ignored.
  - start in the same cycle that done is pulsed is accepted.
- Latency per word with zero-wait memory: 2 cycles (RD then WR).

Test Plan:
- src=16'h1000, dst=16'h2000, len=3, dma_ready always 1.
  - Bus shows addresses 1000R, 2000W, 1002R, 2002W, 1004R, 2004W.
  - Data is copied word for word; done pulses once, 1 cycle after the last WR; words_left=0; err=0.
- Same transfer with dma_ready held 0 for 3 cycles in each RD.
  - dma_addr, dma_en and dma_we stay stable during the stall.
  - Total time is 3*(2+3)=15 cycles; data is correct.
- dst=16'h69FE, len=2.
  - First write to 69FE completes; the second write target 6A00 is never driven with dma_en=1.
  - err=1, no done, words_left=1.
- abort asserted during the second RD of a len=4 transfer.
  - dma_en drops in the same cycle; the next state is IDLE with err=1 and words_left=3.
  - A subsequent start clears err.
- src=16'hFFFE, len=2.
  - Reads occur at FFFE then 0000 (wrap), with no error.
- len=0.
  - done pulses with no dma_en activity.
- reset_n asserted mid-WR.
  - All outputs go to 0 immediately, asynchronously.
